// File: rtl/opl3_host_write_capture_if.sv
// rtl/opl3_host_write_capture_if.sv - host bus inputs and command stream of the OPL3 write capture
interface opl3_host_write_capture_if;
   logic       cs_n_sync;
   logic       wr_n_sync;
   logic [1:0] a_sync;
   logic [7:0] din_sync;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_bank;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       overflow;

   modport master (
      output cs_n_sync, wr_n_sync, a_sync, din_sync, cmd_ready,
      input  cmd_valid, cmd_bank, cmd_addr, cmd_data, overflow
   );

   modport slave (
      input  cs_n_sync, wr_n_sync, a_sync, din_sync, cmd_ready,
      output cmd_valid, cmd_bank, cmd_addr, cmd_data, overflow
   );
endinterface

// File: rtl/opl3_host_write_capture.sv
// rtl/opl3_host_write_capture.sv - OPL3 host write strobe decode into a register-write command FIFO
// Optional minimum-low-width strobe filter: define OPL3_HOST_GLITCH_FILTER_EN.
module opl3_host_write_capture #(
   parameter int FIFO_DEPTH     = 4,
   parameter int MIN_LOW_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   opl3_host_write_capture_if.slave   bus
);
   localparam int            AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

   typedef enum logic {S_IDLE, S_LOW} state_t;

   state_t      state_q, state_d;
   logic        load_hold, strobe_d, strobe_q, long_enough;
   logic [1:0]  hold_a_q;
   logic [7:0]  hold_d_q;
   logic [7:0]  addr_q;
   logic        bank_q, pending_q;
   logic        wr_low;

   assign wr_low = !bus.cs_n_sync && !bus.wr_n_sync;

`ifdef OPL3_HOST_GLITCH_FILTER_EN
   // Counts low samples including the one that entered LOW.
   logic [3:0] low_cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         low_cnt_q <= 4'd0;
      else if (state_q == S_IDLE)
         low_cnt_q <= 4'd1;
      else if (low_cnt_q != 4'hf)
         low_cnt_q <= low_cnt_q + 4'd1;
   end
   assign long_enough = (low_cnt_q >= 4'(MIN_LOW_CYCLES));
`else
   assign long_enough = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         strobe_q <= 1'b0;
         hold_a_q <= 2'd0;
         hold_d_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         if (load_hold) begin
            hold_a_q <= bus.a_sync;
            hold_d_q <= bus.din_sync;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      strobe_d  = 1'b0;
      load_hold = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_low) begin
               state_d   = S_LOW;
               load_hold = 1'b1;
            end
         end
         S_LOW: begin
            if (bus.wr_n_sync) begin
               state_d  = S_IDLE;
               strobe_d = long_enough;
            end else if (bus.cs_n_sync) begin
               state_d  = S_IDLE;
            end else begin
               load_hold = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Address phase only arms the latch; data phases reuse it until the next address write.
   logic push;
   assign push = strobe_q && hold_a_q[0] && pending_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= 8'd0;
         bank_q    <= 1'b0;
         pending_q <= 1'b0;
      end else if (strobe_q && !hold_a_q[0]) begin
         addr_q    <= hold_d_q;
         bank_q    <= hold_a_q[1];
         pending_q <= 1'b1;
      end
   end

   logic [16:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic [16:0] last_q, head;
   logic        empty, full, pop, push_ok, overflow_q;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop     = !empty && bus.cmd_ready;
   assign push_ok = push && (!full || pop);
   assign head    = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_q[AW-1:0]] <= {bank_q, addr_q, hold_d_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         last_q     <= 17'd0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (!empty)
            last_q <= head;
         if (push && full && !pop)
            overflow_q <= 1'b1;
      end
   end

   // Head fields fall back to the last shown entry so they stay put while empty.
   assign bus.cmd_valid = !empty;
   assign {bus.cmd_bank, bus.cmd_addr, bus.cmd_data} = empty ? last_q : head;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_opl3_host_write_capture.sv
// tb/tb_opl3_host_write_capture.sv - self-checking bench for opl3_host_write_capture
module tb_opl3_host_write_capture;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

`ifdef OPL3_HOST_GLITCH_FILTER_EN
   localparam bit GF = 1'b1;
`else
   localparam bit GF = 1'b0;
`endif

   opl3_host_write_capture_if bus();

   opl3_host_write_capture #(.FIFO_DEPTH(4), .MIN_LOW_CYCLES(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   typedef logic [16:0] cmd_t;
   typedef struct {
      logic [1:0] a;
      logic [7:0] din;
      int         low;
      bit         push;
      cmd_t       exp;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   cmd_t sb[$];
   vec_t tbl[9];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got %0h want none", {bus.cmd_bank, bus.cmd_addr, bus.cmd_data});
         end else begin
            cmd_t e;
            e = sb.pop_front();
            check("sb_pop", 32'({bus.cmd_bank, bus.cmd_addr, bus.cmd_data}), 32'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [1:0] a, input logic [7:0] din, input int low, input int gap);
      bus.cs_n_sync = 1'b0;
      bus.wr_n_sync = 1'b0;
      bus.a_sync    = a;
      bus.din_sync  = din;
      repeat (low) tick();
      bus.wr_n_sync = 1'b1;
      bus.cs_n_sync = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic drain(input string name);
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 60 && (sb.size() != 0 || bus.cmd_valid); i++) tick();
      check({name, "_left"}, 32'(sb.size()), 32'd0);
      check({name, "_idle"}, 32'(bus.cmd_valid), 32'd0);
      bus.cmd_ready = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      sb.delete();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cs_n_sync = 1'b1;
      bus.wr_n_sync = 1'b1;
      bus.a_sync    = 2'b00;
      bus.din_sync  = 8'h00;
      bus.cmd_ready = 1'b0;

      tbl[0] = '{2'b00, 8'h20, 3, 1'b0, 17'h0};
      tbl[1] = '{2'b01, 8'h41, 3, 1'b1, {1'b0, 8'h20, 8'h41}};
      tbl[2] = '{2'b01, 8'h42, 1, !GF,  {1'b0, 8'h20, 8'h42}};
      tbl[3] = '{2'b01, 8'h43, 2, 1'b1, {1'b0, 8'h20, 8'h43}};
      tbl[4] = '{2'b10, 8'hB0, 2, 1'b0, 17'h0};
      tbl[5] = '{2'b11, 8'h11, 4, 1'b1, {1'b1, 8'hB0, 8'h11}};
      tbl[6] = '{2'b01, 8'h12, 1, !GF,  {1'b1, 8'hB0, 8'h12}};
      tbl[7] = '{2'b00, 8'h05, 2, 1'b0, 17'h0};
      tbl[8] = '{2'b11, 8'h66, 2, 1'b1, {1'b0, 8'h05, 8'h66}};

      tick();
      check("rst_valid", 32'(bus.cmd_valid), 32'd0);
      check("rst_bank", 32'(bus.cmd_bank), 32'd0);
      check("rst_addr", 32'(bus.cmd_addr), 32'd0);
      check("rst_data", 32'(bus.cmd_data), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      reset_n = 1'b1;
      tick();

      // address then data, end-to-end latency
      host_write(2'b00, 8'h20, 3, 2);
      bus.cs_n_sync = 1'b0;
      bus.wr_n_sync = 1'b0;
      bus.a_sync    = 2'b01;
      bus.din_sync  = 8'h41;
      repeat (3) tick();
      bus.wr_n_sync = 1'b1;
      bus.cs_n_sync = 1'b1;
      tick();
      check("lat_1clk", 32'(bus.cmd_valid), 32'd0);
      tick();
      check("lat_2clk", 32'(bus.cmd_valid), 32'd1);
      check("lat_head", 32'({bus.cmd_bank, bus.cmd_addr, bus.cmd_data}), 32'h02041);
      sb.push_back({1'b0, 8'h20, 8'h41});
      drain("lat");

      // data with no prior address
      do_reset();
      host_write(2'b11, 8'h55, 2, 4);
      check("noaddr_valid", 32'(bus.cmd_valid), 32'd0);
      check("noaddr_ovf", 32'(bus.overflow), 32'd0);

      // bank 1 address, three buffered data writes
      host_write(2'b10, 8'hB0, 2, 2);
      for (int i = 1; i <= 3; i++) begin
         host_write(2'b11, 8'(8'h11 * i), 2, 2);
         sb.push_back({1'b1, 8'hB0, 8'(8'h11 * i)});
      end
      check("buf_valid", 32'(bus.cmd_valid), 32'd1);
      check("buf_ovf", 32'(bus.overflow), 32'd0);
      drain("buf");

      // overflow, then push while full with a simultaneous pop
      do_reset();
      host_write(2'b00, 8'h30, 2, 2);
      for (int i = 1; i <= 6; i++) begin
         host_write(2'b01, 8'(i), 2, 2);
         if (i <= 4) sb.push_back({1'b0, 8'h30, 8'(i)});
      end
      check("ovf_set", 32'(bus.overflow), 32'd1);
      check("ovf_head", 32'({bus.cmd_bank, bus.cmd_addr, bus.cmd_data}), 32'h03001);
      bus.cs_n_sync = 1'b0;
      bus.wr_n_sync = 1'b0;
      bus.a_sync    = 2'b01;
      bus.din_sync  = 8'h07;
      repeat (2) tick();
      bus.wr_n_sync = 1'b1;
      bus.cs_n_sync = 1'b1;
      tick();
      sb.push_back({1'b0, 8'h30, 8'h07});
      bus.cmd_ready = 1'b1;
      tick();
      bus.cmd_ready = 1'b0;
      tick();
      drain("full_pp");
      check("ovf_sticky", 32'(bus.overflow), 32'd1);

      // aborted address write keeps the previous address
      do_reset();
      host_write(2'b00, 8'h10, 2, 2);
      bus.cs_n_sync = 1'b0;
      bus.wr_n_sync = 1'b0;
      bus.a_sync    = 2'b00;
      bus.din_sync  = 8'h40;
      repeat (2) tick();
      bus.cs_n_sync = 1'b1;
      tick();
      bus.wr_n_sync = 1'b1;
      repeat (2) tick();
      sb.push_back({1'b0, 8'h10, 8'h99});
      host_write(2'b01, 8'h99, 2, 3);
      drain("abort");

      // table of writes, including 1-cycle lows
      do_reset();
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].push) sb.push_back(tbl[i].exp);
         host_write(tbl[i].a, tbl[i].din, tbl[i].low, 4);
      end
      drain("table");

      // reset in the middle of a strobe
      host_write(2'b10, 8'h70, 2, 2);
      host_write(2'b01, 8'h01, 2, 3);
      bus.cs_n_sync = 1'b0;
      bus.wr_n_sync = 1'b0;
      bus.a_sync    = 2'b01;
      bus.din_sync  = 8'h02;
      tick();
      reset_n = 1'b0;
      sb.delete();
      tick();
      check("mid_rst_valid", 32'(bus.cmd_valid), 32'd0);
      check("mid_rst_bank", 32'(bus.cmd_bank), 32'd0);
      check("mid_rst_addr", 32'(bus.cmd_addr), 32'd0);
      check("mid_rst_data", 32'(bus.cmd_data), 32'd0);
      check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
      bus.cs_n_sync = 1'b1;
      bus.wr_n_sync = 1'b1;
      reset_n = 1'b1;
      tick();
      host_write(2'b01, 8'h03, 2, 4);
      check("post_rst_nopend", 32'(bus.cmd_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/opl3_host_write_capture.md
Name: opl3_host_write_capture

Overview:
- Sits directly downstream of the 2-stage `synchronizer` on the host-bus inputs (cs_n, wr_n, a[1:0], din[7:0]).
- Detects completed host write strobes and decodes the OPL3 address/data write pairs into full register-write commands {bank, reg addr, data}.
- Buffers the commands in a small FIFO, drained by the OPL3 register file via a valid/ready handshake.
- Single clock domain: the synth clock.

Parameters:
- FIFO_DEPTH, 4, number of buffered register-write commands; power of two, 2..16.
- MIN_LOW_CYCLES, 2, minimum wr_n-low cycles for a strobe to count; only used when the optional feature is compiled in; range 1..15.

Ports:
- clk  input  1  synth clock.
- reset_n  input  1  asynchronous active-low reset; asserts asynchronously, deasserts synchronously to clk upstream.
- cs_n_sync  input  1  synchronized host chip select, active low.
- wr_n_sync  input  1  synchronized host write strobe, active low.
- a_sync  input  2  synchronized host address. Bit 0: 0 = address phase, 1 = data phase. Bit 1: bank select.
- din_sync  input  8  synchronized host data.
- cmd_valid  output  1  FIFO head holds a command.
- cmd_ready  input  1  consumer accepts the head this cycle when high with cmd_valid.
- cmd_bank  output  1  bank of the head command.
- cmd_addr  output  8  register address of the head command.
- cmd_data  output  8  register data of the head command.
- overflow  output  1  sticky: a command was dropped because the FIFO was full.

Behaviour:
- Reset values: cmd_valid=0, cmd_bank=0, cmd_addr=0, cmd_data=0, overflow=0. FIFO empty, pointers 0, addr_pending=0, addr latch=0, strobe FSM in IDLE.
- Reset mid-operation discards the FIFO contents and any pending address phase.
- Strobe FSM states: IDLE, LOW.
  - IDLE -> LOW when cs_n_sync=0 and wr_n_sync=0. Entering LOW loads hold_a and hold_d from a_sync and din_sync.
  - LOW: hold_a/hold_d reload every cycle while cs_n_sync=0 and wr_n_sync=0, so the last sampled low-phase value wins.
  - LOW -> IDLE on wr_n_sync=1. This is a valid strobe edge and produces a one-cycle internal pulse `strobe`.
  - LOW -> IDLE with no strobe if cs_n_sync goes 1 while wr_n_sync is still 0 (aborted write).
- On strobe with hold_a[0]=0 (address phase): addr latch <= hold_d, bank latch <= hold_a[1], addr_pending <= 1. Nothing is pushed.
- On strobe with hold_a[0]=1 (data phase):
  - If addr_pending=1, push {bank latch, addr latch, hold_d}.
  - If addr_pending=0, discard. No overflow, no push.
  - addr_pending stays 1, so repeated data writes reuse the last address, matching OPL3 behaviour.
- Push-to-cmd_valid latency: a push in cycle N gives cmd_valid=1 in cycle N+1 if the FIFO was empty.
- End-to-end latency: wr_n_sync rising sample to cmd_valid = 2 clk.
- FIFO: registered circular buffer with pointer width log2(FIFO_DEPTH)+1; wrap-around on the MSB compare.
  - cmd_bank, cmd_addr and cmd_data show the head entry; they are don't-care-stable (hold last value) when empty.
  - Pop when cmd_valid and cmd_ready.
  - Push and pop in the same cycle when full: pop first, so the push is accepted and count is unchanged.
  - Push when full with no pop: command dropped, overflow <= 1, FIFO unchanged.
  - overflow clears only on reset.
- cmd_ready while empty has no effect.
- Strobes never back-pressure the host; the host is expected to respect OPL3 write timing.

Optional Feature:
- Macro: OPL3_HOST_GLITCH_FILTER_EN.
- Defined:
  - A 4-bit low counter runs in LOW and saturates at 15.
  - The LOW -> IDLE transition on wr_n_sync=1 generates strobe only if the counter >= MIN_LOW_CYCLES.
  - Shorter pulses return to IDLE silently: no address/data update, no push.
- Undefined:
  - No counter is built.
  - Any low of at least 1 cycle counts as a strobe.

Test Plan:
- Address 0x20 bank 0 (a=00, din=0x20, wr low 3 cycles), then data 0x41 (a=01) -> one command {0,0x20,0x41}; cmd_valid rises 2 clk after wr_n_sync rises.
- Data write (a=11, din=0x55) after reset with no address write -> no cmd_valid, overflow=0.
- Address 0xB0 bank 1 (a=10), then three data writes 0x11/0x22/0x33 with cmd_ready=0 -> three FIFO entries {1,0xB0,0x11..0x33}, popped in order once cmd_ready=1.
- FIFO_DEPTH=4, cmd_ready=0, six data writes -> first four retained, overflow=1. Then cmd_ready=1 with a simultaneous push while full -> push accepted, count stays 4.
- cs_n_sync rises while wr_n_sync is low during an address write of 0x40 -> no strobe; the previous address is still used by the next data write.
- With OPL3_HOST_GLITCH_FILTER_EN and MIN_LOW_CYCLES=2: a 1-cycle wr low is ignored, a 2-cycle low is accepted. Without the macro, both are accepted. Assert reset_n=0 mid-strobe -> all outputs return to reset values next edge.
